// File: rtl/imem_fetch_responder.sv
// Instruction-memory fetch responder: issues one synchronous-memory read per accepted
// PC and returns instructions in request order through a small response FIFO.
module imem_fetch_responder #(
  parameter int AW    = 10,
  parameter int DEPTH = 2
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          req_valid_i,
  input  logic [31:0]   req_addr_i,
  output logic          req_ready_o,
  output logic          mem_en_o,
  output logic [AW-1:0] mem_addr_o,
  input  logic [31:0]   mem_rdata_i,
  output logic          instr_valid_o,
  output logic [31:0]   instr_o,
  output logic [31:0]   instr_pc_o,
  output logic          instr_misalign_o,
  input  logic          instr_ready_i,
  input  logic          flush_i
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

  if (DEPTH < 2 || DEPTH > 8) begin : g_bad_depth
    $error("imem_fetch_responder: DEPTH must be in 2..8");
  end

  logic [31:0]   data_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic          mis_q  [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] occ_q;
  logic          infl_q;
  logic [31:0]   infl_pc_q;
  logic          infl_mis_q;

  logic [CW-1:0] count;
  logic          pop;
  logic          push;
  logic          accept;

  // Outstanding read counts against capacity so its response always has a slot.
  assign count  = occ_q + CW'(infl_q);
  assign pop    = instr_valid_o & instr_ready_i;
  assign push   = infl_q;

  assign req_ready_o = !rst_i & !flush_i & ((count < DEPTH_C) | pop);
  assign accept      = req_valid_i & req_ready_o;

  assign mem_en_o   = accept;
  assign mem_addr_o = req_addr_i[AW+1:2];

  assign instr_valid_o    = (occ_q != '0);
  assign instr_o          = data_q[rd_ptr_q];
  assign instr_pc_o       = pc_q[rd_ptr_q];
  assign instr_misalign_o = mis_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
        mis_q[i]  <= 1'b0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      infl_q     <= 1'b0;
      infl_pc_q  <= '0;
      infl_mis_q <= 1'b0;
    end else if (flush_i) begin
      // Redirect: drop queue and the pending response; ignore any pop this cycle.
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      infl_q   <= 1'b0;
    end else begin
      infl_q <= accept;
      if (accept) begin
        infl_pc_q  <= req_addr_i;
        infl_mis_q <= |req_addr_i[1:0];
      end
      if (push) begin
        data_q[wr_ptr_q] <= mem_rdata_i;
        pc_q[wr_ptr_q]   <= infl_pc_q;
        mis_q[wr_ptr_q]  <= infl_mis_q;
        wr_ptr_q         <= (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   occ_q <= occ_q + CW'(1);
        2'b01:   occ_q <= occ_q - CW'(1);
        default: occ_q <= occ_q;
      endcase
    end
  end

  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i) count <= DEPTH_C)
    else $error("imem_fetch_responder: count exceeds DEPTH");

  a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
                                   (push && !pop && !flush_i) |-> (occ_q < DEPTH_C))
    else $error("imem_fetch_responder: push into full FIFO");

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Directed testbench for imem_fetch_responder with a one-cycle-latency memory model.
module tb_imem_fetch_responder;

  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic [31:0]   req_addr;
  logic          req_ready;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata = '0;
  logic          instr_valid;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_misalign;
  logic          instr_ready;
  logic          flush;

  int n_cmp = 0;
  int n_bad = 0;

  imem_fetch_responder #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .req_valid_i      (req_valid),
    .req_addr_i       (req_addr),
    .req_ready_o      (req_ready),
    .mem_en_o         (mem_en),
    .mem_addr_o       (mem_addr),
    .mem_rdata_i      (mem_rdata),
    .instr_valid_o    (instr_valid),
    .instr_o          (instr),
    .instr_pc_o       (instr_pc),
    .instr_misalign_o (instr_misalign),
    .instr_ready_i    (instr_ready),
    .flush_i          (flush)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mdata(input logic [AW-1:0] a);
    return (a == AW'(4)) ? 32'h0050_0093 : (32'hC0DE_0000 | 32'(a));
  endfunction

  always @(posedge clk) if (mem_en) mem_rdata <= mdata(mem_addr);

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; flush = 1'b0; instr_ready = 1'b0;
    req_valid = 1'b1; req_addr = 32'h10;
    #2;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready: got %b want 0", req_ready); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL rst_mem_en: got %b want 0", mem_en); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL rst_instr: got %h want 0", instr); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL rst_pc: got %h want 0", instr_pc); end
    n_cmp++; if (instr_misalign !== 1'b0) begin n_bad++; $display("FAIL rst_mis: got %b want 0", instr_misalign); end
    req_valid = 1'b0;
    #8 rst = 1'b0;
  endtask

  task automatic test_single;
    cyc;
    req_valid = 1'b1; req_addr = 32'h10; instr_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL single_ready: got %b want 1", req_ready); end
    n_cmp++; if (mem_en !== 1'b1) begin n_bad++; $display("FAIL single_mem_en: got %b want 1", mem_en); end
    n_cmp++; if (mem_addr !== AW'(4)) begin n_bad++; $display("FAIL single_mem_addr: got %h want 4", mem_addr); end
    cyc;
    req_valid = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL single_early: got %b want 0", instr_valid); end
    cyc; #1;
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1", instr_valid); end
    n_cmp++; if (instr !== 32'h0050_0093) begin n_bad++; $display("FAIL single_instr: got %h want 00500093", instr); end
    n_cmp++; if (instr_pc !== 32'h10) begin n_bad++; $display("FAIL single_pc: got %h want 10", instr_pc); end
    n_cmp++; if (instr_misalign !== 1'b0) begin n_bad++; $display("FAIL single_mis: got %b want 0", instr_misalign); end
    cyc; #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL single_drain: got %b want 0", instr_valid); end
  endtask

  task automatic test_misalign;
    cyc;
    req_valid = 1'b1; req_addr = 32'h6; instr_ready = 1'b1;
    #1;
    n_cmp++; if (mem_addr !== AW'(1)) begin n_bad++; $display("FAIL mis_mem_addr: got %h want 1", mem_addr); end
    cyc;
    req_valid = 1'b0;
    cyc; #1;
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL mis_valid: got %b want 1", instr_valid); end
    n_cmp++; if (instr_pc !== 32'h6) begin n_bad++; $display("FAIL mis_pc: got %h want 6", instr_pc); end
    n_cmp++; if (instr_misalign !== 1'b1) begin n_bad++; $display("FAIL mis_flag: got %b want 1", instr_misalign); end
    n_cmp++; if (instr !== 32'hC0DE_0001) begin n_bad++; $display("FAIL mis_instr: got %h want c0de0001", instr); end
    cyc;
  endtask

  task automatic test_stream;
    for (int k = 0; k < 65; k++) begin
      req_valid = (k < 63); req_addr = 32'(4 * k); instr_ready = 1'b1;
      #1;
      if (k < 63) begin
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL stream_ready k=%0d: got %b want 1", k, req_ready); end
      end
      if (k >= 2) begin
        n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL stream_bubble k=%0d: got %b want 1", k, instr_valid); end
        n_cmp++; if (instr_pc !== 32'(4 * (k - 2))) begin n_bad++; $display("FAIL stream_pc k=%0d: got %h want %h", k, instr_pc, 32'(4 * (k - 2))); end
        n_cmp++; if (instr !== mdata(AW'(k - 2))) begin n_bad++; $display("FAIL stream_instr k=%0d: got %h want %h", k, instr, mdata(AW'(k - 2))); end
      end
      cyc;
    end
    req_valid = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL stream_end: got %b want 0", instr_valid); end
    cyc;
  endtask

  task automatic test_stall;
    int occ = 0, infl = 0, req_idx = 0, exp_idx = 0, not_ready = 0;
    logic pop_m, rdy_m;
    logic [31:0] base = 32'h200;
    for (int c = 0; c < 30; c++) begin
      req_valid = (c < 15); req_addr = base + 32'(4 * req_idx);
      instr_ready = (c >= 3 && c <= 7) ? 1'b0 : 1'b1;
      #1;
      pop_m = (occ != 0) && instr_ready;
      rdy_m = ((occ + infl) < DEPTH) || pop_m;
      n_cmp++; if (req_ready !== rdy_m) begin n_bad++; $display("FAIL stall_ready c=%0d: got %b want %b", c, req_ready, rdy_m); end
      n_cmp++; if (instr_valid !== (occ != 0)) begin n_bad++; $display("FAIL stall_valid c=%0d: got %b want %b", c, instr_valid, occ != 0); end
      if (occ != 0) begin
        n_cmp++; if (instr_pc !== base + 32'(4 * exp_idx)) begin n_bad++; $display("FAIL stall_pc c=%0d: got %h want %h", c, instr_pc, base + 32'(4 * exp_idx)); end
        n_cmp++; if (instr !== mdata(AW'(128 + exp_idx))) begin n_bad++; $display("FAIL stall_instr c=%0d: got %h want %h", c, instr, mdata(AW'(128 + exp_idx))); end
      end
      if (req_valid && !req_ready) not_ready++;
      if (pop_m) exp_idx++;
      occ = occ + infl - (pop_m ? 1 : 0);
      infl = (req_valid && rdy_m) ? 1 : 0;
      if (infl == 1) req_idx++;
      cyc;
    end
    n_cmp++; if (not_ready !== 3) begin n_bad++; $display("FAIL stall_full_cycles: got %0d want 3", not_ready); end
    n_cmp++; if (exp_idx !== 12) begin n_bad++; $display("FAIL stall_delivered: got %0d want 12", exp_idx); end
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL stall_empty: got %b want 0", instr_valid); end
  endtask

  task automatic test_flush;
    instr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1; req_addr = 32'h300 + 32'(4 * c);
      #1;
      n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_fill c=%0d: got %b want 1", c, req_ready); end
      cyc;
    end
    flush = 1'b1; req_valid = 1'b1; req_addr = 32'h50; instr_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL flush_ready: got %b want 0", req_ready); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL flush_mem_en: got %b want 0", mem_en); end
    cyc;
    flush = 1'b0; req_addr = 32'h40;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid1: got %b want 0", instr_valid); end
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL flush_after_ready: got %b want 1", req_ready); end
    n_cmp++; if (mem_addr !== AW'(16)) begin n_bad++; $display("FAIL flush_mem_addr: got %h want 10", mem_addr); end
    cyc;
    req_valid = 1'b0;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid2: got %b want 0", instr_valid); end
    cyc; #1;
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL flush_new_valid: got %b want 1", instr_valid); end
    n_cmp++; if (instr_pc !== 32'h40) begin n_bad++; $display("FAIL flush_new_pc: got %h want 40", instr_pc); end
    n_cmp++; if (instr !== 32'hC0DE_0010) begin n_bad++; $display("FAIL flush_new_instr: got %h want c0de0010", instr); end
    cyc; #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL flush_no_stale: got %b want 0", instr_valid); end
    cyc;
  endtask

  task automatic test_async_reset;
    instr_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      req_valid = 1'b1; req_addr = 32'h400 + 32'(4 * c);
      cyc;
    end
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL ares_filled: got %b want 1", instr_valid); end
    #3 rst = 1'b1;
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL ares_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instr !== 32'h0) begin n_bad++; $display("FAIL ares_instr: got %h want 0", instr); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL ares_pc: got %h want 0", instr_pc); end
    n_cmp++; if (req_ready !== 1'b0) begin n_bad++; $display("FAIL ares_ready: got %b want 0", req_ready); end
    n_cmp++; if (mem_en !== 1'b0) begin n_bad++; $display("FAIL ares_mem_en: got %b want 0", mem_en); end
    req_valid = 1'b0;
    @(posedge clk);
    #5 rst = 1'b0;
    cyc;
    req_valid = 1'b1; req_addr = 32'h0; instr_ready = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL ares_first_ready: got %b want 1", req_ready); end
    cyc;
    req_valid = 1'b0;
    cyc; #1;
    n_cmp++; if (instr_valid !== 1'b1) begin n_bad++; $display("FAIL ares_resp_valid: got %b want 1", instr_valid); end
    n_cmp++; if (instr_pc !== 32'h0) begin n_bad++; $display("FAIL ares_resp_pc: got %h want 0", instr_pc); end
    n_cmp++; if (instr !== 32'hC0DE_0000) begin n_bad++; $display("FAIL ares_resp_instr: got %h want c0de0000", instr); end
    for (int c = 0; c < 4; c++) begin
      cyc; #1;
      n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL ares_no_old c=%0d: got %b want 0", c, instr_valid); end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_misalign;
    test_stream;
    test_stall;
    test_flush;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
